// File: rtl/gate_array_pkg.sv
// Shared types for the multi-input gate array: gate function encoding and
// the per-mode reduction helper used by every channel.
package gate_array_pkg;

    typedef enum logic [1:0] {
        GM_NAND = 2'd0,
        GM_AND  = 2'd1,
        GM_NOR  = 2'd2,
        GM_OR   = 2'd3
    } gate_mode_t;

    // Callers pass the AND- and OR-reductions of a slice, so the helper stays width-agnostic.
    function automatic logic gate_reduce(input gate_mode_t mode,
                                         input logic       all_set,
                                         input logic       any_set);
        logic r;
        r = 1'b0;
        case (mode)
            GM_NAND: r = ~all_set;
            GM_AND:  r =  all_set;
            GM_NOR:  r = ~any_set;
            GM_OR:   r =  any_set;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multi_input_gate_array_inertial_filter.sv
// Purpose: per-bit inertial filter; q follows d only after d persists DELAY_CYCLES sampled cycles.
// Latency: d sampled at edge k reaches q at edge k+DELAY_CYCLES (DELAY_CYCLES+1 edges from d).
// Backpressure: none; en low freezes s/cnt/q and clears toggled.
module inertial_filter #(
    parameter int   DELAY_CYCLES = 1,
    parameter logic RST_BIT      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q,
    output logic toggled
);

    localparam int             CW       = $clog2(DELAY_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          s;
    logic [CW-1:0] cnt;

    // s != q is the PENDING state; any revert of s drops the run count entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s       <= RST_BIT;
            cnt     <= '0;
            q       <= RST_BIT;
            toggled <= 1'b0;
        end else if (en) begin
            s <= d;
            if (s == q) begin
                cnt     <= '0;
                toggled <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                q       <= s;
                cnt     <= '0;
                toggled <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_ONE;
                toggled <= 1'b0;
            end
        end else begin
            toggled <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_input_gate_array.sv
// Purpose: CHANNELS independent INPUTS-wide gates (NAND/AND/NOR/OR) with inertial-filtered outputs.
// Latency: a stable din/mode change reaches y after DELAY_CYCLES+1 enabled edges; outputs registered.
// Backpressure: none; en low freezes all state and suppresses changed pulses.
module multi_input_gate_array
    import gate_array_pkg::*;
#(
    parameter int                    CHANNELS     = 3,
    parameter int                    INPUTS       = 3,
    parameter int                    DELAY_CYCLES = 1,
    parameter logic [CHANNELS-1:0]   Y_RST        = '1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*INPUTS-1:0]   din,
    output logic [CHANNELS-1:0]          y,
    output logic [CHANNELS-1:0]          changed
);

    gate_mode_t          mode_sel;
    logic [CHANNELS-1:0] raw;

    assign mode_sel = gate_mode_t'(mode);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [INPUTS-1:0] slice;

        assign slice  = din[i*INPUTS +: INPUTS];
        assign raw[i] = gate_reduce(mode_sel, &slice, |slice);

        inertial_filter #(
            .DELAY_CYCLES (DELAY_CYCLES),
            .RST_BIT      (Y_RST[i])
        ) u_filter (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .d       (raw[i]),
            .q       (y[i]),
            .toggled (changed[i])
        );
    end

endmodule

// File: tb/tb_multi_input_gate_array.sv
// Directed bench for multi_input_gate_array with CHANNELS=3, INPUTS=3, DELAY_CYCLES=4.
module tb_multi_input_gate_array;

    logic       clk;
    logic       clk_on;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [8:0] din;
    logic [2:0] y;
    logic [2:0] changed;

    int errors;
    int checks;

    multi_input_gate_array #(
        .CHANNELS     (3),
        .INPUTS       (3),
        .DELAY_CYCLES (4),
        .Y_RST        (3'b111)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .din     (din),
        .y       (y),
        .changed (changed)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_on) clk = ~clk;
        end
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a new mode/din, expect y held for 4 edges and committed on the 5th.
    task automatic settle(input string tag, input logic [1:0] m, input logic [8:0] d,
                          input logic [2:0] prev_y, input logic [2:0] new_y);
        mode = m;
        din  = d;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk({tag, "_hold_y"}, y, prev_y);
            chk({tag, "_hold_chg"}, changed, 3'b000);
        end
        tick();
        chk({tag, "_commit_y"}, y, new_y);
        chk({tag, "_commit_chg"}, changed, prev_y ^ new_y);
        tick();
        chk({tag, "_after_y"}, y, new_y);
        chk({tag, "_after_chg"}, changed, 3'b000);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clk_on = 1'b0;
        rst_n  = 1'b1;
        en     = 1'b1;
        mode   = 2'd0;
        din    = 9'd0;

        // Reset with the clock stopped
        #1 rst_n = 1'b0;
        #1;
        chk("rst_y", y, 3'b111);
        chk("rst_chg", changed, 3'b000);
        #1 rst_n = 1'b1;
        clk_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_y", y, 3'b111);
            chk("post_rst_chg", changed, 3'b000);
        end

        // Commit on channel 0 and back
        settle("commit", 2'd0, 9'b000_000_111, 3'b111, 3'b110);
        settle("uncommit", 2'd0, 9'b000_000_000, 3'b110, 3'b111);

        // 3-cycle glitch is suppressed
        din = 9'b000_000_111;
        tick(); tick(); tick();
        din = 9'b000_000_000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("glitch3_y", y, 3'b111);
            chk("glitch3_chg", changed, 3'b000);
        end

        // 4-cycle pulse passes, then reverts 4 edges after the revert is sampled
        din = 9'b000_000_111;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pulse4_pre_y", y, 3'b111);
        end
        din = 9'b000_000_000;
        tick();
        chk("pulse4_fall_y", y, 3'b110);
        chk("pulse4_fall_chg", changed, 3'b001);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pulse4_low_y", y, 3'b110);
            chk("pulse4_low_chg", changed, 3'b000);
        end
        tick();
        chk("pulse4_rise_y", y, 3'b111);
        chk("pulse4_rise_chg", changed, 3'b001);
        tick();
        chk("pulse4_end_chg", changed, 3'b000);

        // Mode switches: all channels move together
        settle("mode_and", 2'd1, 9'b000_000_000, 3'b111, 3'b000);
        settle("mode_nand", 2'd0, 9'b000_000_000, 3'b000, 3'b111);

        // Mixed patterns across all four functions
        settle("or_mix",   2'd3, 9'b111_010_000, 3'b111, 3'b110);
        settle("nor_mix",  2'd2, 9'b111_010_000, 3'b110, 3'b001);
        settle("and_mix",  2'd1, 9'b111_101_111, 3'b001, 3'b101);
        settle("nand_mix", 2'd0, 9'b111_101_111, 3'b101, 3'b010);
        settle("nand_zero", 2'd0, 9'b000_000_000, 3'b010, 3'b111);

        // Enable hold: sample + 2 counts, 5 frozen edges, commit on 2nd enabled edge
        din = 9'b000_000_111;
        tick(); tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en_off_y", y, 3'b111);
            chk("en_off_chg", changed, 3'b000);
        end
        en = 1'b1;
        tick();
        chk("en_back1_y", y, 3'b111);
        tick();
        chk("en_back2_y", y, 3'b110);
        chk("en_back2_chg", changed, 3'b001);

        // Mid-count asynchronous reset, then a full count is required
        din = 9'b000_000_000;
        tick(); tick(); tick();
        chk("midrst_pending_y", y, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async_y", y, 3'b111);
        chk("midrst_async_chg", changed, 3'b000);
        #1;
        din   = 9'b000_000_111;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_recount_y", y, 3'b111);
        end
        tick();
        chk("midrst_commit_y", y, 3'b110);
        chk("midrst_commit_chg", changed, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a stalled clock.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
